// File: rtl/hoop_game_ctrl.sv
// Hoop scoring game sequencer: sensor synchronizer/debouncer, IDLE/PLAY/OVER
// state machine, saturating BCD score and BCD countdown timer.
module hoop_game_ctrl #(
   parameter int TICK_DIV     = 50000000,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int GAME_SECS    = 60,
   parameter int MAX_SCORE    = 99
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       start,
   input  logic       hoop_in,
   output logic [7:0] score_bcd,
   output logic [7:0] time_bcd,
   output logic [1:0] game_state,
   output logic       playing,
   output logic       game_over,
   output logic       score_pulse
);

   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [7:0] GAME_BCD = {4'(GAME_SECS / 10), 4'(GAME_SECS % 10)};
   localparam logic [7:0] MAX_BCD  = {4'(MAX_SCORE / 10), 4'(MAX_SCORE % 10)};

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_OVER = 2'b10
   } state_e;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         return {v[7:4] + 4'd1, 4'd0};
      end else begin
         return {v[7:4], v[3:0] + 4'd1};
      end
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0) begin
         return {v[7:4] - 4'd1, 4'd9};
      end else begin
         return {v[7:4], v[3:0] - 4'd1};
      end
   endfunction

   logic              sync1_q, sync1_d, sync2_q, sync2_d;
   logic              deb_q, deb_d, deb_dly_q, deb_dly_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic              start_q, start_d;
   state_e            state_q, state_d;
   logic [7:0]        score_q, score_d;
   logic [7:0]        time_q, time_d;
   logic              pulse_q, pulse_d;
   logic              basket_s, start_edge_s;

   // Sensor path: two-flop synchronizer feeding a run-length debouncer.
   always_comb begin
      sync1_d   = hoop_in;
      sync2_d   = sync1_q;
      deb_dly_d = deb_q;
      deb_d     = deb_q;
      db_cnt_d  = '0;
      if (sync2_q != deb_q) begin
         if (db_cnt_q == DB_LAST) begin
            deb_d    = ~deb_q;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end else begin
         db_cnt_d = '0;
      end
   end

   // Game state machine, score and countdown; a basket only counts in PLAY.
   always_comb begin
      basket_s     = deb_q & ~deb_dly_q & (state_q == ST_PLAY);
      start_edge_s = start & ~start_q;
      start_d      = start;
      pulse_d      = basket_s;
      state_d      = state_q;
      score_d      = score_q;
      time_d       = time_q;
      tick_d       = tick_q;
      case (state_q)
         ST_PLAY: begin
            if (basket_s && (score_q != MAX_BCD)) begin
               score_d = bcd_inc(score_q);
            end else begin
               score_d = score_q;
            end
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               time_d = bcd_dec(time_q);
               if (time_q == 8'h01) begin
                  state_d = ST_OVER;
               end else begin
                  state_d = ST_PLAY;
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         ST_IDLE, ST_OVER: begin
            if (start_edge_s) begin
               state_d = ST_PLAY;
               score_d = 8'h00;
               time_d  = GAME_BCD;
               tick_d  = '0;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_q     <= 1'b0;
         deb_dly_q <= 1'b0;
         db_cnt_q  <= '0;
         tick_q    <= '0;
         start_q   <= 1'b0;
         state_q   <= ST_IDLE;
         score_q   <= 8'h00;
         time_q    <= GAME_BCD;
         pulse_q   <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_dly_d;
         db_cnt_q  <= db_cnt_d;
         tick_q    <= tick_d;
         start_q   <= start_d;
         state_q   <= state_d;
         score_q   <= score_d;
         time_q    <= time_d;
         pulse_q   <= pulse_d;
      end
   end

   assign score_bcd   = score_q;
   assign time_bcd    = time_q;
   assign game_state  = state_q;
   assign playing     = (state_q == ST_PLAY);
   assign game_over   = (state_q == ST_OVER);
   assign score_pulse = pulse_q;

endmodule

// File: tb/tb_hoop_game_ctrl.sv
// Bench for hoop_game_ctrl: vector table, hand-written corner sequences and a
// randomized run against an integer-level reference model.
module tb_hoop_game_ctrl;

   localparam int TICK = 10;
   localparam int DB   = 4;
   localparam int GAME = 3;
   localparam int MAXS = 99;

   logic clk = 1'b0;
   logic resetn;
   logic start_a, hoop_a, start_b, hoop_b;
   logic [7:0] score_a, time_a, score_b, time_b;
   logic [1:0] st_a, st_b;
   logic play_a, over_a, pulse_a, play_b, over_b, pulse_b;

   int n_checks = 0;
   int n_errors = 0;
   int pulse_cnt_b = 0;

   always #5 clk = ~clk;

   hoop_game_ctrl #(.TICK_DIV(TICK), .DEBOUNCE_CYC(DB), .GAME_SECS(GAME), .MAX_SCORE(MAXS)) dut_a (
      .clock(clk), .resetn(resetn), .start(start_a), .hoop_in(hoop_a),
      .score_bcd(score_a), .time_bcd(time_a), .game_state(st_a),
      .playing(play_a), .game_over(over_a), .score_pulse(pulse_a));

   hoop_game_ctrl #(.TICK_DIV(10), .DEBOUNCE_CYC(4), .GAME_SECS(60), .MAX_SCORE(12)) dut_b (
      .clock(clk), .resetn(resetn), .start(start_b), .hoop_in(hoop_b),
      .score_bcd(score_b), .time_bcd(time_b), .game_state(st_b),
      .playing(play_b), .game_over(over_b), .score_pulse(pulse_b));

   always @(negedge clk) begin
      if (pulse_b) pulse_cnt_b <= pulse_cnt_b + 1;
   end

   // Reference model for dut_a: raw sample history, seconds and score as integers.
   bit raw_q[$];
   int m_deb, m_deb_prev, m_start_prev, m_state, m_score, m_secs, m_play;
   bit m_pulse, m_basket, m_flip;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         raw_q = {};
         for (int i = 0; i < DB + 2; i++) raw_q.push_back(1'b0);
         m_deb = 0; m_deb_prev = 0; m_start_prev = 0; m_state = 0;
         m_score = 0; m_secs = GAME; m_play = 0; m_pulse = 1'b0;
      end else begin
         m_basket = (m_deb == 1) && (m_deb_prev == 0) && (m_state == 1);
         raw_q.push_back(hoop_a);
         if (raw_q.size() > DB + 2) void'(raw_q.pop_front());
         // level flips once the last DB synchronized samples all disagree with it
         m_flip = 1'b1;
         for (int i = 0; i < DB; i++) if (int'(raw_q[i]) == m_deb) m_flip = 1'b0;
         m_deb_prev = m_deb;
         if (m_flip) m_deb = 1 - m_deb;
         m_pulse = m_basket;
         if (m_state == 1) begin
            if (m_basket && m_score < MAXS) m_score++;
            m_play++;
            m_secs = GAME - m_play / TICK;
            if (m_secs == 0) m_state = 2;
         end else if (start_a && !m_start_prev) begin
            m_state = 1; m_score = 0; m_secs = GAME; m_play = 0;
         end
         m_start_prev = start_a;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_a(input string tag, input logic [1:0] st, input logic [7:0] tm,
                        input logic [7:0] sc, input logic pl);
      chk({tag, "_state"}, {6'd0, st_a}, {6'd0, st});
      chk({tag, "_time"}, time_a, tm);
      chk({tag, "_score"}, score_a, sc);
      chk({tag, "_pulse"}, {7'd0, pulse_a}, {7'd0, pl});
      chk({tag, "_playing"}, {7'd0, play_a}, {7'd0, (st == 2'd1)});
      chk({tag, "_over"}, {7'd0, over_a}, {7'd0, (st == 2'd2)});
   endtask

   task automatic hit_b();
      hoop_b = 1'b1; run(8);
      hoop_b = 1'b0; run(8);
   endtask

   typedef struct {
      logic       start;
      logic       hoop;
      int         n;
      logic [1:0] st;
      logic [7:0] tm;
      logic [7:0] sc;
      logic       pl;
   } vec_t;

   vec_t tbl[22];
   int   base_b;

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1,  2'd1, 8'h03, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 9,  2'd1, 8'h03, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1,  2'd1, 8'h02, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 10, 2'd1, 8'h01, 8'h00, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 9,  2'd1, 8'h01, 8'h00, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 1,  2'd2, 8'h00, 8'h00, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 5,  2'd2, 8'h00, 8'h00, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 1,  2'd1, 8'h03, 8'h00, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 6,  2'd1, 8'h03, 8'h00, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1,  2'd1, 8'h03, 8'h01, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 2,  2'd1, 8'h03, 8'h01, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 8,  2'd1, 8'h02, 8'h01, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 3,  2'd1, 8'h01, 8'h01, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 6,  2'd1, 8'h01, 8'h01, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 1,  2'd1, 8'h01, 8'h01, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 1,  2'd1, 8'h01, 8'h01, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 1,  2'd1, 8'h01, 8'h01, 1'b0};
      tbl[17] = '{1'b0, 1'b1, 1,  2'd2, 8'h00, 8'h01, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 6,  2'd2, 8'h00, 8'h01, 1'b0};
      tbl[19] = '{1'b0, 1'b1, 10, 2'd2, 8'h00, 8'h01, 1'b0};
      tbl[20] = '{1'b0, 1'b0, 8,  2'd2, 8'h00, 8'h01, 1'b0};
      tbl[21] = '{1'b1, 1'b0, 1,  2'd1, 8'h03, 8'h00, 1'b0};

      resetn = 1'b1; start_a = 1'b0; hoop_a = 1'b0; start_b = 1'b0; hoop_b = 1'b0;
      @(posedge clk); #3;
      resetn = 1'b0; #1;
      chk_a("reset", 2'd0, 8'h03, 8'h00, 1'b0);
      @(negedge clk); resetn = 1'b1;
      run(2);
      chk_a("idle", 2'd0, 8'h03, 8'h00, 1'b0);

      for (int i = 0; i < 22; i++) begin
         start_a = tbl[i].start; hoop_a = tbl[i].hoop;
         run(tbl[i].n);
         chk_a($sformatf("tbl%0d", i), tbl[i].st, tbl[i].tm, tbl[i].sc, tbl[i].pl);
      end

      // basket landing on the final tick
      start_a = 1'b0; hoop_a = 1'b0; run(23);
      hoop_a = 1'b1; run(6);
      chk_a("final_pre", 2'd1, 8'h01, 8'h00, 1'b0);
      run(1);
      chk_a("final_hit", 2'd2, 8'h00, 8'h01, 1'b1);

      // basket coinciding with start in OVER: start wins
      hoop_a = 1'b0; run(8);
      hoop_a = 1'b1; run(6);
      start_a = 1'b1; run(1);
      chk_a("over_start", 2'd1, 8'h03, 8'h00, 1'b0);
      start_a = 1'b0; run(3);
      chk_a("over_start_after", 2'd1, 8'h03, 8'h00, 1'b0);

      // reset in the middle of a game
      hoop_a = 1'b0; run(2); #2;
      resetn = 1'b0; #1;
      chk_a("mid_reset", 2'd0, 8'h03, 8'h00, 1'b0);
      @(negedge clk); resetn = 1'b1;
      run(5);
      chk_a("post_reset_idle", 2'd0, 8'h03, 8'h00, 1'b0);
      start_a = 1'b1; run(1);
      chk_a("post_reset_start", 2'd1, 8'h03, 8'h00, 1'b0);
      start_a = 1'b0;

      // carry and saturation on the MAX_SCORE=12 instance
      start_b = 1'b1; run(1); start_b = 1'b0;
      chk("b_start_state", {6'd0, st_b}, 8'h01);
      chk("b_start_time", time_b, 8'h60);
      base_b = pulse_cnt_b;
      for (int i = 0; i < 10; i++) hit_b();
      chk("b_carry_score", score_b, 8'h10);
      chk("b_carry_pulses", 8'(pulse_cnt_b - base_b), 8'd10);
      for (int i = 0; i < 5; i++) hit_b();
      chk("b_sat_score", score_b, 8'h12);
      chk("b_sat_pulses", 8'(pulse_cnt_b - base_b), 8'd15);
      chk("b_sat_state", {6'd0, st_b}, 8'h01);

      // randomized run against the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         chk("rnd_score", score_a, {4'(m_score / 10), 4'(m_score % 10)});
         chk("rnd_time", time_a, {4'(m_secs / 10), 4'(m_secs % 10)});
         chk("rnd_state", {6'd0, st_a}, 8'(m_state));
         chk("rnd_playing", {7'd0, play_a}, {7'd0, (m_state == 1)});
         chk("rnd_over", {7'd0, over_a}, {7'd0, (m_state == 2)});
         chk("rnd_pulse", {7'd0, pulse_a}, {7'd0, m_pulse});
         if ($urandom_range(5, 0) == 0) hoop_a = ~hoop_a;
         start_a = ($urandom_range(39, 0) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
